ifft_twiddle_mult: RTL

IFFT_TWIDDLE_MULT -- requirements
Module: ifft_twiddle_mult

---
 rtl/ifft_pkg.sv | 24 ++
 rtl/ifft_twiddle_mult_if.sv | 31 +++
 rtl/ifft_cmul_sat.sv | 37 +++
 rtl/ifft_twiddle_mult.sv | 82 ++++++++
 4 files changed

// File: rtl/ifft_pkg.sv
// Shared widths and the saturation helper for the IFFT twiddle multiplier.
package ifft_pkg;

    localparam int unsigned DW       = 16;
    localparam int unsigned FRAC     = 8;
    localparam int unsigned TW_DEPTH = 28;
    localparam int unsigned TW_AW    = 5;

    // Clamp a sign-extended value to the signed range of a w-bit word (w <= 63).
    function automatic logic signed [63:0] sat_to(input logic signed [63:0] v,
                                                  input int unsigned       w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/ifft_twiddle_mult_if.sv
// Sample stream, product stream and twiddle ROM port of the twiddle multiplier.
interface ifft_twiddle_mult_if #(
    parameter int unsigned DW    = ifft_pkg::DW,
    parameter int unsigned TW_AW = ifft_pkg::TW_AW
);

    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sop;
    logic signed [DW-1:0] in_re;
    logic signed [DW-1:0] in_im;
    logic [TW_AW-1:0]     tw_addr;
    logic signed [DW-1:0] tw_re;
    logic signed [DW-1:0] tw_im;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_re;
    logic signed [DW-1:0] out_im;
    logic                 out_eop;

    modport slave (
        input  in_valid, in_sop, in_re, in_im, tw_re, tw_im, out_ready,
        output in_ready, tw_addr, out_valid, out_re, out_im, out_eop
    );

    modport master (
        output in_valid, in_sop, in_re, in_im, tw_re, tw_im, out_ready,
        input  in_ready, tw_addr, out_valid, out_re, out_im, out_eop
    );

endinterface

// File: rtl/ifft_cmul_sat.sv
// Combinational complex multiply with arithmetic right shift and saturation to DW bits.
module ifft_cmul_sat #(
    parameter int unsigned DW   = ifft_pkg::DW,
    parameter int unsigned FRAC = ifft_pkg::FRAC
) (
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    output logic signed [DW-1:0] y_re,
    output logic signed [DW-1:0] y_im
);
    import ifft_pkg::*;

    logic signed [2*DW-1:0] p_rr;
    logic signed [2*DW-1:0] p_ii;
    logic signed [2*DW-1:0] p_ri;
    logic signed [2*DW-1:0] p_ir;
    logic signed [2*DW:0]   s_re;
    logic signed [2*DW:0]   s_im;
    logic signed [2*DW:0]   sh_re;
    logic signed [2*DW:0]   sh_im;

    always_comb begin
        p_rr  = a_re * b_re;
        p_ii  = a_im * b_im;
        p_ri  = a_re * b_im;
        p_ir  = a_im * b_re;
        s_re  = (2*DW+1)'(p_rr) - (2*DW+1)'(p_ii);
        s_im  = (2*DW+1)'(p_ri) + (2*DW+1)'(p_ir);
        sh_re = s_re >>> FRAC;
        sh_im = s_im >>> FRAC;
        y_re  = DW'(sat_to(64'(sh_re), DW));
        y_im  = DW'(sat_to(64'(sh_im), DW));
    end

endmodule

// File: rtl/ifft_twiddle_mult.sv
// Two-stage twiddle multiplier: S1 holds the sample while the external ROM reads its twiddle.
module ifft_twiddle_mult #(
    parameter int unsigned DW       = ifft_pkg::DW,
    parameter int unsigned FRAC     = ifft_pkg::FRAC,
    parameter int unsigned TW_DEPTH = ifft_pkg::TW_DEPTH,
    parameter int unsigned TW_AW    = ifft_pkg::TW_AW
) (
    input  logic                clk,
    input  logic                rst,
    ifft_twiddle_mult_if.slave  bus
);
    import ifft_pkg::*;

    localparam logic [TW_AW-1:0] LAST_IDX = TW_AW'(TW_DEPTH - 1);

    logic                 s1_valid;
    logic signed [DW-1:0] s1_re;
    logic signed [DW-1:0] s1_im;
    logic [TW_AW-1:0]     s1_idx;
    logic [TW_AW-1:0]     cnt;
    logic [TW_AW-1:0]     next_idx;
    logic                 s1_adv;
    logic                 stall;
    logic                 accept;
    logic signed [DW-1:0] prod_re;
    logic signed [DW-1:0] prod_im;

    // While stalled the ROM address is pinned to S1 so its registered data stays aligned.
    always_comb begin
        s1_adv       = !bus.out_valid || bus.out_ready;
        stall        = s1_valid && !s1_adv;
        bus.in_ready = !stall;
        accept       = bus.in_valid && bus.in_ready;
        next_idx     = bus.in_sop ? '0 : cnt;
        bus.tw_addr  = stall ? s1_idx : next_idx;
    end

    ifft_cmul_sat #(
        .DW   (DW),
        .FRAC (FRAC)
    ) u_cmul (
        .a_re (s1_re),
        .a_im (s1_im),
        .b_re (bus.tw_re),
        .b_im (bus.tw_im),
        .y_re (prod_re),
        .y_im (prod_im)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            s1_valid      <= 1'b0;
            s1_re         <= '0;
            s1_im         <= '0;
            s1_idx        <= '0;
            bus.out_valid <= 1'b0;
            bus.out_re    <= '0;
            bus.out_im    <= '0;
            bus.out_eop   <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_re    <= bus.in_re;
                s1_im    <= bus.in_im;
                s1_idx   <= next_idx;
                cnt      <= (next_idx == LAST_IDX) ? '0 : next_idx + 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            if (s1_adv) begin
                bus.out_valid <= s1_valid;
                if (s1_valid) begin
                    bus.out_re  <= prod_re;
                    bus.out_im  <= prod_im;
                    bus.out_eop <= (s1_idx == LAST_IDX);
                end
            end
        end
    end

endmodule
